interrupt_control_ict_arbiter: RTL

Holds the 64-entry Interrupt Configuration Table (ICT) filled by the IDT reader, latches device interrupt requests into a 64-bit pending vector, and presents the highest-priority eligible interrupt to the pipeline core. It sits directly downstream of the IDT read stage, consuming its ICT write strobes, and upstream of the core's exception/interrupt entry logic.

---
 rtl/interrupt_control_ict_arbiter_if.sv | 26 ++
 rtl/interrupt_control_ict_arbiter.sv | 63 ++++++
 2 files changed

// File: rtl/interrupt_control_ict_arbiter_if.sv
// interrupt_control_ict_arbiter_if: ICT write, device request and core presentation signals
interface interrupt_control_ict_arbiter_if;
  logic       iICT_REQ;
  logic [5:0] iICT_ENTRY;
  logic       iICT_CONF_MASK;
  logic       iICT_CONF_VALID;
  logic [1:0] iICT_CONF_LEVEL;
  logic       iINTERRUPT_ENABLE;
  logic       iIRQ_SET;
  logic [5:0] iIRQ_SET_NUM;
  logic       iIRQ_ACK;
  logic       oIRQ_VALID;
  logic [5:0] oIRQ_NUM;
  logic [1:0] oIRQ_LEVEL;
  logic       oPENDING_ANY;
  modport master (
    output iICT_REQ, iICT_ENTRY, iICT_CONF_MASK, iICT_CONF_VALID, iICT_CONF_LEVEL,
    output iINTERRUPT_ENABLE, iIRQ_SET, iIRQ_SET_NUM, iIRQ_ACK,
    input  oIRQ_VALID, oIRQ_NUM, oIRQ_LEVEL, oPENDING_ANY
  );
  modport slave (
    input  iICT_REQ, iICT_ENTRY, iICT_CONF_MASK, iICT_CONF_VALID, iICT_CONF_LEVEL,
    input  iINTERRUPT_ENABLE, iIRQ_SET, iIRQ_SET_NUM, iIRQ_ACK,
    output oIRQ_VALID, oIRQ_NUM, oIRQ_LEVEL, oPENDING_ANY
  );
endinterface

// File: rtl/interrupt_control_ict_arbiter.sv
// interrupt_control_ict_arbiter: 64-entry ICT, pending latch and priority presentation to the core
module interrupt_control_ict_arbiter (
  input logic iCLOCK,
  input logic inRESET,
  interrupt_control_ict_arbiter_if.slave bus
);
  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] PRESENT = 1'b1;
  logic [63:0]      t_valid, t_mask, pending, pending_nxt, eligible;
  logic [63:0][1:0] t_level;
  logic [0:0]       state;
  logic [5:0]       b_irq_num, win_num;
  logic [1:0]       b_irq_level, win_level;
  logic             b_irq_valid, win_any;
  assign b_irq_valid = state == PRESENT;
  assign eligible    = pending & t_valid & ~t_mask;
  // strict compare keeps the lowest index among equal levels
  always_comb begin
    win_any   = 1'b0;
    win_num   = '0;
    win_level = '0;
    for (int i = 0; i < 64; i++)
      if (eligible[i] && (!win_any || t_level[i] > win_level)) begin
        win_any   = 1'b1;
        win_num   = 6'(i);
        win_level = t_level[i];
      end
  end
  // set is applied after the ack clear so a colliding set wins
  always_comb begin
    pending_nxt = pending;
    if (b_irq_valid && bus.iIRQ_ACK) pending_nxt[b_irq_num] = 1'b0;
    if (bus.iIRQ_SET && t_valid[bus.iIRQ_SET_NUM]) pending_nxt[bus.iIRQ_SET_NUM] = 1'b1;
  end
  always_ff @(posedge iCLOCK) begin
    if (!inRESET) begin
      t_valid     <= '0;
      t_mask      <= '0;
      t_level     <= '0;
      pending     <= '0;
      state       <= IDLE;
      b_irq_num   <= '0;
      b_irq_level <= '0;
    end else begin
      if (bus.iICT_REQ) begin
        t_valid[bus.iICT_ENTRY] <= bus.iICT_CONF_VALID;
        t_mask[bus.iICT_ENTRY]  <= bus.iICT_CONF_MASK;
        t_level[bus.iICT_ENTRY] <= bus.iICT_CONF_LEVEL;
      end
      pending <= pending_nxt;
      if (state == IDLE && bus.iINTERRUPT_ENABLE && win_any) begin
        state       <= PRESENT;
        b_irq_num   <= win_num;
        b_irq_level <= win_level;
      end else if (state == PRESENT && bus.iIRQ_ACK)
        state <= IDLE;
    end
  end
  assign bus.oIRQ_VALID   = b_irq_valid;
  assign bus.oIRQ_NUM     = b_irq_num;
  assign bus.oIRQ_LEVEL   = b_irq_level;
  assign bus.oPENDING_ANY = |pending;
endmodule
